// File: rtl/wb_write_queue.sv
// wb_write_queue: write-back initiator for the register file write port.
// Completed results enter an in-order FIFO and leave one per cycle through a
// registered output stage (regWrite/writeReg/writeData). Two lookup ports
// return the youngest pending value for a register so that decode can see
// results that have not yet been committed.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        result handshake (in_ready combinational: count < DEPTH)
//   in_reg, in_data          destination register and result value
//   wb_hold                  suppress draining this cycle
//   regWrite/writeReg/       registered write to the register file
//   writeData
//   lookup_reg1/2            forwarding queries
//   hit1/2, hit_data1/2      combinational forwarding results (data 0 on miss)
//   count                    entries queued, excluding the output stage
module wb_write_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_reg,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       wb_hold,
  output logic                       regWrite,
  output logic [ADDR_W-1:0]          writeReg,
  output logic [DATA_W-1:0]          writeData,
  input  logic [ADDR_W-1:0]          lookup_reg1,
  input  logic [ADDR_W-1:0]          lookup_reg2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [DATA_W-1:0]          hit_data1,
  output logic [DATA_W-1:0]          hit_data2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]  write_reg_q, write_reg_d;
  logic [DATA_W-1:0]  write_data_q, write_data_d;

  logic push_nz;
  logic pop;
  logic bypass;
  logic enq;

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign regWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign count     = count_q;

  // Handshake decode, pointer/count update and output-stage selection.
  always_comb begin
    push_nz      = in_valid && in_ready && (in_reg != '0);
    pop          = !wb_hold && (count_q != '0);
    // An empty, unheld queue hands the arrival straight to the output stage.
    bypass       = !wb_hold && (count_q == '0) && push_nz;
    enq          = push_nz && !bypass;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (enq && !pop)      count_d = count_q + CNT_W'(1);
    else if (!enq && pop) count_d = count_q - CNT_W'(1);

    if (pop) begin
      reg_write_d  = 1'b1;
      write_reg_d  = mem_q[rd_ptr_q].rd;
      write_data_d = mem_q[rd_ptr_q].data;
    end else if (bypass) begin
      reg_write_d  = 1'b1;
      write_reg_d  = in_reg;
      write_data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= '{rd: in_reg, data: in_data};
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
    logic              hit;
    logic [DATA_W-1:0] d;
    logic [PTR_W-1:0]  idx;
    hit = 1'b0;
    d   = '0;
    if (a != '0) begin
      if (reg_write_q && (write_reg_q == a)) begin
        hit = 1'b1;
        d   = write_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (mem_q[idx].rd == a)) begin
          hit = 1'b1;
          d   = mem_q[idx].data;
        end
      end
    end
    return {hit, d};
  endfunction

  always_comb begin
    {hit1, hit_data1} = lookup(lookup_reg1);
    {hit2, hit_data2} = lookup(lookup_reg2);
  end

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        wb_hold;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  lookup_reg1, lookup_reg2;
  logic        hit1, hit2;
  logic [31:0] hit_data1, hit_data2;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_write_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .wb_hold(wb_hold),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .lookup_reg1(lookup_reg1), .lookup_reg2(lookup_reg2),
    .hit1(hit1), .hit2(hit2), .hit_data1(hit_data1), .hit_data2(hit_data2),
    .count(count)
  );

  // Reference model: a queue of pending writes plus the single write in flight.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  bit          m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  task automatic model_reset();
    mq.delete();
    m_rw = 1'b0;
    m_wr = '0;
    m_wd = '0;
  endtask

  task automatic model_edge();
    bit   acc;
    bit   nz;
    ent_t e;
    acc = in_valid && (mq.size() < DEPTH);
    nz  = acc && (in_reg != 5'd0);
    e.r = in_reg;
    e.d = in_data;
    if (wb_hold) begin
      m_rw = 1'b0;
      if (nz) mq.push_back(e);
    end else if (mq.size() > 0) begin
      ent_t h;
      h = mq.pop_front();
      m_rw = 1'b1; m_wr = h.r; m_wd = h.d;
      if (nz) mq.push_back(e);
    end else if (nz) begin
      m_rw = 1'b1; m_wr = e.r; m_wd = e.d;
    end else begin
      m_rw = 1'b0;
    end
  endtask

  // Youngest first: queue back to front, then the in-flight write.
  function automatic logic [32:0] model_fwd(input logic [4:0] a);
    if (a == 5'd0) return 33'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].r == a) return {1'b1, mq[i].d};
    if (m_rw && m_wr == a) return {1'b1, m_wd};
    return 33'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] r, input logic [31:0] d, input bit h);
    @(negedge clk);
    in_valid = v; in_reg = r; in_data = d; wb_hold = h;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_reg = 0; in_data = 0; wb_hold = 0;
    lookup_reg1 = 0; lookup_reg2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL reset_regWrite: got %0h expected 0", regWrite); end
    checks++; if (writeReg !== 5'd0) begin errors++; $display("FAIL reset_writeReg: got %0h expected 0", writeReg); end
    checks++; if (writeData !== 32'd0) begin errors++; $display("FAIL reset_writeData: got %0h expected 0", writeData); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0h expected 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    drive(1, 5'd5, 32'hDEADBEEF, 0);
    lookup_reg1 = 5'd5;
    #1;
    checks++; if (hit1 !== 1'b0) begin errors++; $display("FAIL single_no_input_fwd: got %0h expected 0", hit1); end
    tick();
    checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL single_regWrite: got %0h expected 1", regWrite); end
    checks++; if (writeReg !== 5'd5) begin errors++; $display("FAIL single_writeReg: got %0d expected 5", writeReg); end
    checks++; if (writeData !== 32'hDEADBEEF) begin errors++; $display("FAIL single_writeData: got %0h expected deadbeef", writeData); end
    checks++; if (hit1 !== 1'b1 || hit_data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_out_fwd: got %0h/%0h expected 1/deadbeef", hit1, hit_data1); end
    drive(0, 5'd0, 32'd0, 0);
    tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL single_idle_regWrite: got %0h expected 0", regWrite); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_idle_count: got %0d expected 0", count); end
    lookup_reg1 = 5'd0;
  endtask

  task automatic test_zero_reg();
    drive(1, 5'd0, 32'h1234, 0);
    lookup_reg1 = 5'd0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready: got %0h expected 1", in_ready); end
    tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL zero_regWrite: got %0h expected 0", regWrite); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", count); end
    checks++; if (hit1 !== 1'b0) begin errors++; $display("FAIL zero_hit: got %0h expected 0", hit1); end
    drive(0, 5'd0, 32'd0, 0);
    tick();
  endtask

  task automatic test_full_and_drain();
    logic [4:0]  exp_r [5];
    logic [31:0] exp_d [5];
    logic [2:0]  exp_c [5];
    exp_r = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
    exp_d = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h66};
    exp_c = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(i), 32'(i * 'h11), 1);
      tick();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %0h expected 0", in_ready); end
    drive(1, 5'd6, 32'h66, 1);
    tick();
    checks++; if (count !== 3'd4 || regWrite !== 1'b0) begin errors++; $display("FAIL full_stall: got count=%0d rw=%0h expected 4/0", count, regWrite); end
    drive(1, 5'd6, 32'h66, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      checks++;
      if (regWrite !== 1'b1 || writeReg !== exp_r[i] || writeData !== exp_d[i] || count !== exp_c[i]) begin
        errors++;
        $display("FAIL drain_%0d: got rw=%0h r=%0d d=%0h c=%0d expected 1/%0d/%0h/%0d",
                 i, regWrite, writeReg, writeData, count, exp_r[i], exp_d[i], exp_c[i]);
      end
    end
    drive(0, 5'd0, 32'd0, 0);
    tick();
    checks++; if (regWrite !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drain_done: got rw=%0h c=%0d expected 0/0", regWrite, count); end
  endtask

  task automatic test_forward();
    drive(1, 5'd7, 32'hA, 1);
    tick();
    drive(1, 5'd7, 32'hB, 1);
    tick();
    drive(0, 5'd0, 32'd0, 1);
    lookup_reg1 = 5'd7; lookup_reg2 = 5'd0;
    #1;
    checks++; if (hit1 !== 1'b1 || hit_data1 !== 32'hB) begin errors++; $display("FAIL fwd_youngest: got %0h/%0h expected 1/b", hit1, hit_data1); end
    checks++; if (hit2 !== 1'b0 || hit_data2 !== 32'd0) begin errors++; $display("FAIL fwd_zero: got %0h/%0h expected 0/0", hit2, hit_data2); end
    wb_hold = 1'b0;
    tick();
    checks++; if (writeData !== 32'hA || hit_data1 !== 32'hB) begin errors++; $display("FAIL fwd_first_pop: got wd=%0h hd=%0h expected a/b", writeData, hit_data1); end
    tick();
    checks++; if (writeData !== 32'hB || hit1 !== 1'b1 || hit_data1 !== 32'hB) begin errors++; $display("FAIL fwd_second_pop: got wd=%0h hit=%0h hd=%0h expected b/1/b", writeData, hit1, hit_data1); end
    tick();
    checks++; if (hit1 !== 1'b0 || hit_data1 !== 32'd0) begin errors++; $display("FAIL fwd_empty: got %0h/%0h expected 0/0", hit1, hit_data1); end
    lookup_reg1 = 5'd0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(i + 10), 32'(i + 100), 1);
      tick();
    end
    drive(0, 5'd0, 32'd0, 0);
    tick();
    checks++; if (count !== 3'd3 || regWrite !== 1'b1) begin errors++; $display("FAIL prereset: got c=%0d rw=%0h expected 3/1", count, regWrite); end
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (regWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'd0 || count !== 3'd0) begin
      errors++; $display("FAIL async_reset: got rw=%0h r=%0d d=%0h c=%0d expected all 0", regWrite, writeReg, writeData, count);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (regWrite !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL post_reset_%0d: got rw=%0h c=%0d expected 0/0", i, regWrite, count); end
    end
  endtask

  task automatic test_random();
    logic [32:0] f1, f2;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0));
      lookup_reg1 = 5'($urandom_range(0, 7));
      lookup_reg2 = 5'($urandom_range(0, 7));
      #1;
      f1 = model_fwd(lookup_reg1);
      f2 = model_fwd(lookup_reg2);
      checks++; if (in_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_in_ready@%0d: got %0h expected %0h", n, in_ready, (mq.size() < DEPTH)); end
      checks++; if ({hit1, hit_data1} !== f1) begin errors++; $display("FAIL rnd_fwd1@%0d: got %0h/%0h expected %0h/%0h", n, hit1, hit_data1, f1[32], f1[31:0]); end
      checks++; if ({hit2, hit_data2} !== f2) begin errors++; $display("FAIL rnd_fwd2@%0d: got %0h/%0h expected %0h/%0h", n, hit2, hit_data2, f2[32], f2[31:0]); end
      tick();
      checks++; if (regWrite !== m_rw || count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_state@%0d: got rw=%0h c=%0d expected %0h/%0d", n, regWrite, count, m_rw, mq.size()); end
      if (m_rw) begin
        checks++; if (writeReg !== m_wr || writeData !== m_wd) begin errors++; $display("FAIL rnd_write@%0d: got %0d/%0h expected %0d/%0h", n, writeReg, writeData, m_wr, m_wd); end
      end
    end
    drive(0, 5'd0, 32'd0, 0);
    repeat (DEPTH + 2) tick();
    checks++; if (regWrite !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rnd_drain: got rw=%0h c=%0d expected 0/0", regWrite, count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_reg();
    test_full_and_drain();
    test_forward();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
